// File: rtl/outport_alloc.sv
// outport_alloc: wormhole output-port allocator for one router output.
// Round-robin picks one of five inputs, locks the crossbar select from head
// to tail flit, and gates every flit transfer on downstream credits.
// Optional: define OUTALLOC_STARVE_EN to add per-input wait counters that
// override round-robin once an input has waited STARVE_LIM cycles.
module outport_alloc #(
    parameter int unsigned PORTID     = 0,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CRW        = 4,
    parameter int unsigned STARVE_LIM = 16
) (
    input  logic           clk,
    input  logic           rst_,
    input  logic [4:0]     req,
    input  logic [14:0]    dst,
    input  logic [4:0]     tail,
    input  logic           credit_in,
    output logic [4:0]     sel,
    output logic [4:0]     grt,
    output logic [CRW-1:0] credits,
    output logic           stall,
    output logic           cr_err
);
    localparam logic [2:0]     PID    = 3'(PORTID);
    localparam logic [CRW-1:0] CR_MAX = CRW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOCK, S_STALL} state_t;

    state_t         state_q, state_d;
    logic [4:0]     sel_q, sel_d;
    logic [2:0]     rr_q, rr_d;
    logic [CRW-1:0] credits_q, credits_d;
    logic           cr_err_q, cr_err_d;
    logic [4:0]     cand;
    logic [4:0]     grt_c;
    logic [2:0]     rr_idx;
    logic [2:0]     win_idx;
    logic [2:0]     own_idx;
    logic           alloc;
    logic           cred_ok;

    function automatic logic [2:0] wrap5(input logic [2:0] base, input int unsigned off);
        int unsigned s;
        s = (32'(base) + off) % 5;
        return 3'(s);
    endfunction

    assign cred_ok = (credits_q != '0);

    // Candidates: inputs presenting a flit addressed to this output
    always_comb begin
        cand = '0;
        for (int unsigned i = 0; i < 5; i++)
            cand[i] = req[i] && (dst[3*i +: 3] == PID);
    end

    // Round-robin search upward from rr+1; descending loop so the nearest wins
    always_comb begin
        rr_idx = '0;
        for (int unsigned k = 5; k >= 1; k--)
            if (cand[wrap5(rr_q, k)])
                rr_idx = wrap5(rr_q, k);
    end

    // Index of the current owner, used to seed rr when its tail leaves
    always_comb begin
        own_idx = '0;
        for (int unsigned i = 0; i < 5; i++)
            if (sel_q[i])
                own_idx = 3'(i);
    end

`ifdef OUTALLOC_STARVE_EN
    localparam logic [5:0] LIM = 6'(STARVE_LIM);

    logic [4:0][4:0] wait_q, wait_d;
    logic            stv_hit;
    logic [2:0]      stv_idx;

    // Lowest-index starved candidate overrides the round-robin choice
    always_comb begin
        stv_hit = 1'b0;
        stv_idx = '0;
        for (int unsigned i = 5; i >= 1; i--)
            if (cand[i-1] && ({1'b0, wait_q[i-1]} >= LIM)) begin
                stv_hit = 1'b1;
                stv_idx = 3'(i - 1);
            end
    end

    // Winner selection with starvation override
    always_comb win_idx = stv_hit ? stv_idx : rr_idx;

    // Saturating wait counters: count while waiting, clear on winning
    always_comb begin
        wait_d = wait_q;
        for (int unsigned i = 0; i < 5; i++) begin
            if (alloc && (win_idx == 3'(i)))
                wait_d[i] = '0;
            else if (cand[i] && !sel_q[i] && (wait_q[i] != '1))
                wait_d[i] = wait_q[i] + 5'd1;
        end
    end

    // Wait counter registers
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) wait_q <= '0;
        else       wait_q <= wait_d;
    end
`else
    // Winner selection: pure round-robin
    always_comb win_idx = rr_idx;
`endif

    // Allocation FSM: next state, owner latch, grant gating
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        grt_c   = '0;
        alloc   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((cand != '0) && cred_ok) begin
                    alloc   = 1'b1;
                    sel_d   = 5'b00001 << win_idx;
                    state_d = S_LOCK;
                end
            end
            S_LOCK: begin
                if (cred_ok) begin
                    grt_c = sel_q & req;
                    if ((grt_c & tail) != '0) begin
                        state_d = S_IDLE;
                        sel_d   = '0;
                        rr_d    = own_idx;
                    end
                end else if ((sel_q & req) != '0) begin
                    state_d = S_STALL;
                end
            end
            S_STALL: begin
                // Leave on the edge where the count turns non-zero
                if (cred_ok || credit_in)
                    state_d = S_LOCK;
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = '0;
            end
        endcase
    end

    // Credit counter and sticky overflow flag
    always_comb begin
        credits_d = credits_q;
        cr_err_d  = cr_err_q;
        if ((grt_c != '0) && !credit_in) begin
            credits_d = credits_q - CRW'(1);
        end else if (credit_in && (grt_c == '0)) begin
            if (credits_q == CR_MAX)
                cr_err_d = 1'b1;
            else
                credits_d = credits_q + CRW'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            rr_q      <= 3'd4;
            credits_q <= CR_MAX;
            cr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rr_q      <= rr_d;
            credits_q <= credits_d;
            cr_err_q  <= cr_err_d;
        end
    end

    assign sel     = sel_q;
    assign grt     = grt_c;
    assign credits = credits_q;
    assign stall   = (state_q == S_STALL);
    assign cr_err  = cr_err_q;

endmodule

// File: tb/tb_outport_alloc.sv
// Randomized scoreboard bench for outport_alloc. The driver applies random
// packet traffic and credit returns on the falling edge, computes the expected
// observable outputs from a behavioural model and queues them; a monitor pops
// and compares each cycle. Also exercises an asynchronous mid-packet reset.
module tb_outport_alloc;
    localparam int PID   = 2;
    localparam int DEPTH = 4;
    localparam int CRW   = 4;
    localparam int SLIM  = 3;
    localparam int NCYC  = 1500;

    logic           clk = 1'b0;
    logic           rst_ = 1'b0;
    logic [4:0]     req = '0;
    logic [14:0]    dst = '0;
    logic [4:0]     tail = '0;
    logic           credit_in = 1'b0;
    logic [4:0]     sel;
    logic [4:0]     grt;
    logic [CRW-1:0] credits;
    logic           stall;
    logic           cr_err;

    outport_alloc #(
        .PORTID    (PID),
        .DEPTH     (DEPTH),
        .CRW       (CRW),
        .STARVE_LIM(SLIM)
    ) dut (
        .clk      (clk),
        .rst_     (rst_),
        .req      (req),
        .dst      (dst),
        .tail     (tail),
        .credit_in(credit_in),
        .sel      (sel),
        .grt      (grt),
        .credits  (credits),
        .stall    (stall),
        .cr_err   (cr_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]     sel;
        logic [4:0]     grt;
        logic [CRW-1:0] cred;
        logic           stall;
        logic           crerr;
    } exp_t;

    exp_t expq[$];
    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model: mode 0=idle 1=locked 2=stalled; owner -1 when idle
    int m_mode, m_own, m_rr, m_cred;
    bit m_err;
    int m_wait[5];

    // Per-input packet source
    int p_len[5];
    int p_dst[5];
    bit p_head[5];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, got, want);
        end
    endtask

    task automatic new_pkt(input int i);
        p_len[i]  = $urandom_range(1, 4);
        p_dst[i]  = ($urandom % 2 == 0) ? PID : int'($urandom % 8);
        p_head[i] = 1'b1;
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_own  = -1;
        m_rr   = 4;
        m_cred = DEPTH;
        m_err  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            m_wait[i] = 0;
            new_pkt(i);
        end
    endtask

    // Monitor: compare every queued expectation against the DUT
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("sel",     32'(sel),     32'(e.sel));
                chk("grt",     32'(grt),     32'(e.grt));
                chk("credits", 32'(credits), 32'(e.cred));
                chk("stall",   32'(stall),   32'(e.stall));
                chk("cr_err",  32'(cr_err),  32'(e.crerr));
            end
        end
    end

    // Driver and reference model
    initial begin
        int pct[6] = '{60, 15, 90, 30, -1, 60};
        bit did_rst;
        logic [4:0]  rv, tv, cand;
        logic [14:0] dv;
        logic        ci;
        int          g, win, p, fd;
        bit          was_locked;
        exp_t        e;

        did_rst = 1'b0;
        model_reset();
        #12 rst_ = 1'b1;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            p = pct[cyc / 250];
            rv = '0; tv = '0; dv = '0; cand = '0;
            for (int i = 0; i < 5; i++) begin
                rv[i] = ($urandom % 100) < 75;
                fd = p_head[i] ? p_dst[i] : int'($urandom % 8);
                dv[3*i +: 3] = 3'(fd);
                tv[i] = (p_len[i] == 1);
                cand[i] = rv[i] && (fd == PID);
            end
            if (p < 0) ci = ($urandom % 2) == 0;
            else       ci = (DEPTH - m_cred > 0) && (($urandom % 100) < p);
            req = rv; dst = dv; tail = tv; credit_in = ci;

            // Observable outputs for this cycle
            g = -1;
            if (m_mode == 1 && m_cred > 0 && rv[m_own]) g = m_own;
            e.sel   = (m_own < 0) ? 5'd0 : 5'(1 << m_own);
            e.grt   = (g < 0) ? 5'd0 : 5'(1 << g);
            e.cred  = CRW'(m_cred);
            e.stall = (m_mode == 2);
            e.crerr = m_err;
            expq.push_back(e);
            was_locked = (m_mode == 1);

            // Next state
            win = -1;
            if (m_mode == 0 && cand != '0 && m_cred > 0) begin
`ifdef OUTALLOC_STARVE_EN
                for (int i = 0; i < 5; i++)
                    if (win < 0 && cand[i] && m_wait[i] >= SLIM) win = i;
`endif
                for (int k = 1; k <= 5; k++)
                    if (win < 0 && cand[(m_rr + k) % 5]) win = (m_rr + k) % 5;
            end
`ifdef OUTALLOC_STARVE_EN
            for (int i = 0; i < 5; i++) begin
                if (win == i) m_wait[i] = 0;
                else if (cand[i] && m_own != i && m_wait[i] < 31) m_wait[i]++;
            end
`endif
            if (m_mode == 0) begin
                if (win >= 0) begin m_own = win; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (m_cred > 0) begin
                    if (g >= 0 && tv[g]) begin m_rr = g; m_own = -1; m_mode = 0; end
                end else if (rv[m_own]) begin
                    m_mode = 2;
                end
            end else begin
                if (m_cred > 0 || ci) m_mode = 1;
            end
            if (g >= 0 && !ci) m_cred--;
            else if (ci && g < 0) begin
                if (m_cred == DEPTH) m_err = 1'b1;
                else m_cred++;
            end

            // Advance packet sources
            for (int i = 0; i < 5; i++) begin
                if (i == g) begin
                    p_len[i]--;
                    p_head[i] = 1'b0;
                    if (p_len[i] == 0) new_pkt(i);
                end else if (p_head[i] && p_dst[i] != PID && ($urandom % 8) == 0) begin
                    new_pkt(i);
                end
            end

            // One asynchronous reset between edges while a packet is in flight
            if (!did_rst && cyc >= 1250 && was_locked) begin
                did_rst = 1'b1;
                #3 rst_ = 1'b0;
                #1;
                chk("rst_sel",     32'(sel),     32'd0);
                chk("rst_credits", 32'(credits), 32'(DEPTH));
                chk("rst_grt",     32'(grt),     32'd0);
                chk("rst_stall",   32'(stall),   32'd0);
                chk("rst_cr_err",  32'(cr_err),  32'd0);
                @(posedge clk);
                #1 rst_ = 1'b1;
                model_reset();
            end
        end

        @(negedge clk);
        #3;
        chk("queue_drained", 32'(expq.size()), 32'd0);
        if (!did_rst) chk("reset_exercised", 32'(did_rst), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/outport_alloc.md
Name: outport_alloc

Overview:
- Packet-level (wormhole) output-port allocator for one router output; one instance per output port.
- Picks one of 5 input ports by round-robin and locks the crossbar select to that input from head flit to tail flit.
- Tracks downstream buffer credits and gates flit transfer.
- Sits between the input-port controllers and the output crossbar mux.

Parameters:
- PORTID, 0, id of the output port this instance serves (compared with input destination ids)
- DEPTH, 4, downstream buffer depth = credit count at reset (1..15)
- CRW, 4, credit counter width; must satisfy 2^CRW > DEPTH
- STARVE_LIM, 16, wait-cycle threshold for the optional starvation boost

Ports:
- clk  in  1  clock, rising edge
- rst_  in  1  reset, asynchronous, active-low
- req  in  5  req[i]=1: input i presents a flit this cycle
- dst  in  15  dst[3i+2:3i]: destination port id of input i's flit; meaningful on head flits only
- tail  in  5  tail[i]=1: input i's current flit is a tail (head+tail = single-flit packet)
- credit_in  in  1  one-cycle pulse: downstream freed one slot
- sel  out  5  registered one-hot owner; drives crossbar select; 0 when idle
- grt  out  5  combinational one-hot; grt[i]=1 means input i's flit transfers this cycle
- credits  out  CRW  current credit count
- stall  out  1  1 in STALL state
- cr_err  out  1  sticky: credit_in received while credits==DEPTH

Behaviour:
Reset (async assert, sync release) values:
- state=IDLE, sel=0, grt=0, rr pointer=4 (input 0 has top priority first), credits=DEPTH, stall=0, cr_err=0.

States:
- IDLE
  - cand = req & (dst_i == PORTID).
  - If cand!=0 and credits>0: winner = first set bit of cand searching upward from rr+1, wrapping mod 5. Latch sel=onehot(winner), go LOCK.
  - grt=0 in IDLE. Allocation latency is 1 cycle; the head flit moves in the first LOCK cycle.
  - If cand!=0 and credits==0: stay IDLE, no latch.
- LOCK
  - grt = sel & req when credits>0, else 0.
  - credits==0 and the owner requests: go STALL.
  - grt[o] & tail[o]: at the clock edge go IDLE, sel=0, rr=o.
  - Owner deasserts req (bubble): hold LOCK, grt=0, no timeout.
- STALL
  - grt=0, stall=1.
  - On the cycle credits becomes >0, return to LOCK. The first flit moves in the cycle after the return.

Credits:
- grt!=0 alone: credits-1.
- credit_in alone: credits+1.
- Both in the same cycle: unchanged.
- credits never underflows, because grt is gated by credits>0.
- credit_in while credits==DEPTH and no grt: ignored, cr_err set, cleared only by reset.

Other rules:
- Other inputs' dst matching PORTID while locked are ignored; no preemption.
- Back-to-back packets: at least one IDLE cycle (bubble) between tail and next head grant.
- sel and grt are always one-hot or zero; grt is a subset of sel.
- Reset asserted mid-packet: immediate return to reset values; the partial packet is abandoned.

Optional Feature:
- Macro: OUTALLOC_STARVE_EN.
- Defined:
  - Per-input 5-bit saturating wait counter increments each cycle cand[i]=1 and i is not sel, and clears when i wins.
  - In IDLE, if any counter >= STARVE_LIM, the lowest-index such input wins regardless of rr; rr is then updated normally.
- Undefined: pure round-robin; counters absent.

Test Plan:
- Reset, PORTID=2, req=00001, dst_0=2, tail_0 on 3rd flit, credits 4 -> sel=00001 after 1 cycle, grt[0] on 3 cycles, credits=1, IDLE, rr=0.
- Inputs 1,3,4 all request port 2 continuously, 1-flit packets, credit_in each grant -> grant order 1,3,4,1,3,4 with one bubble each.
- DEPTH=2, 4-flit packet, no credit_in -> 2 flits pass, stall=1, grt=0; credit_in pulse -> STALL to LOCK, 1 flit next cycle.
- credit_in and grt in the same cycle at credits=1 -> credits stays 1; credit_in at credits=DEPTH idle -> cr_err=1.
- Owner req drops for 3 cycles mid-packet while input 4 requests -> sel unchanged, grt=0, no switch until tail.
- rst_ low mid-packet (asynchronous, between edges) -> sel=0, credits=DEPTH immediately. With OUTALLOC_STARVE_EN, STARVE_LIM=3, input 0 blocked 3 cycles -> input 0 wins next IDLE over rr choice.
